// File: rtl/solver_pkg.sv
// Shared types for the DPLL search controller: FSM states and assignment-trail entries.
package solver_pkg;

  // Widest variable index a trail entry can carry; the controller's VAR_W must not exceed it.
  localparam int TRAIL_VAR_W = 16;

  localparam logic TYPE_DECISION = 1'b1;
  localparam logic TYPE_FORCED   = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECIDE,
    ST_ASSIGN,
    ST_BCP,
    ST_WAIT_BCP,
    ST_BACKTRACK,
    ST_SAT,
    ST_UNSAT
  } ctrl_state_t;

  typedef struct packed {
    logic [TRAIL_VAR_W-1:0] var_idx;
    logic                   val;
    logic                   is_decision;
  } trail_entry_t;

  function automatic trail_entry_t make_entry(input logic [TRAIL_VAR_W-1:0] v,
                                              input logic val,
                                              input logic is_dec);
    trail_entry_t e;
    e.var_idx     = v;
    e.val         = val;
    e.is_decision = is_dec;
    return e;
  endfunction

endpackage

// File: rtl/solver_ctrl_if.sv
// Handshake bundle between the search controller and the implication queue,
// decide unit, variable-state table and BCP engine.
interface solver_ctrl_if #(
  parameter int VAR_W = 7,
  parameter int CNT_W = 32
);
  logic             start;
  logic             imp_valid;
  logic [VAR_W-1:0] imp_var;
  logic             imp_val;
  logic             imp_ready;
  logic             imp_flush;
  logic             dec_req;
  logic             dec_valid;
  logic [VAR_W-1:0] dec_var;
  logic             dec_val;
  logic             dec_none;
  logic             asg_we;
  logic [VAR_W-1:0] asg_var;
  logic             asg_val;
  logic             asg_clear;
  logic             bcp_start;
  logic [VAR_W-1:0] bcp_var;
  logic             bcp_val;
  logic             bcp_done;
  logic             bcp_conflict;
  logic             busy;
  logic             sat;
  logic             unsat;
  logic [VAR_W:0]   level;
  logic [CNT_W-1:0] conflicts;
  logic             err;

  modport master (
    input  start, imp_valid, imp_var, imp_val, dec_valid, dec_var, dec_val, dec_none,
           bcp_done, bcp_conflict,
    output imp_ready, imp_flush, dec_req, asg_we, asg_var, asg_val, asg_clear,
           bcp_start, bcp_var, bcp_val, busy, sat, unsat, level, conflicts, err
  );

  modport slave (
    output start, imp_valid, imp_var, imp_val, dec_valid, dec_var, dec_val, dec_none,
           bcp_done, bcp_conflict,
    input  imp_ready, imp_flush, dec_req, asg_we, asg_var, asg_val, asg_clear,
           bcp_start, bcp_var, bcp_val, busy, sat, unsat, level, conflicts, err
  );
endinterface

// File: rtl/assign_trail.sv
// LIFO of assignment records for chronological backtracking; the top entry is
// held in a register so it is valid the cycle after any push or pop.
module assign_trail
  import solver_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  input  trail_entry_t                 push_entry_i,
  output trail_entry_t                 top_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  trail_entry_t     mem_q [DEPTH];
  trail_entry_t     top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] below_idx;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_push   = push_i && !full_o && !clear_i;
  assign do_pop    = pop_i && !empty_o && !push_i && !clear_i;
  assign below_idx = count_q - CNT_W'(2);
  assign top_o     = top_q;
  assign count_o   = count_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[count_q[PTR_W-1:0]] <= push_entry_i;
    end
  end

  // After a pop the new top is the entry below the old one, read straight into top_q.
  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    if (clear_i) begin
      count_d = '0;
      top_d   = '0;
    end else if (do_push) begin
      count_d = count_q + CNT_W'(1);
      top_d   = push_entry_i;
    end else if (do_pop) begin
      count_d = count_q - CNT_W'(1);
      top_d   = (count_q > CNT_W'(1)) ? mem_q[below_idx[PTR_W-1:0]] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      top_q   <= '0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
    end
  end

endmodule

// File: rtl/solver_ctrl.sv
// DPLL search controller: fetch/decide/assign/BCP loop with chronological
// backtracking over an internal assignment trail.
module solver_ctrl
  import solver_pkg::*;
#(
  parameter int NUM_VARIABLE = 128,
  parameter int VAR_W        = $clog2(NUM_VARIABLE),
  parameter int CNT_W        = 32
) (
  input logic           clock,
  input logic           reset_n,
  solver_ctrl_if.master bus
);
  ctrl_state_t       state_q, state_d;
  logic [VAR_W-1:0]  var_q, var_d;
  logic              val_q, val_d;
  logic              type_q, type_d;
  logic [VAR_W:0]    level_q, level_d;
  logic [CNT_W-1:0]  conflicts_q, conflicts_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;

  logic              trail_push, trail_pop, trail_clear;
  trail_entry_t      trail_top;
  logic              trail_empty, trail_full;
  logic [$clog2(NUM_VARIABLE+1)-1:0] trail_count;

  assign_trail #(.DEPTH(NUM_VARIABLE)) u_trail (
    .clock        (clock),
    .reset_n      (reset_n),
    .push_i       (trail_push),
    .pop_i        (trail_pop),
    .clear_i      (trail_clear),
    .push_entry_i (make_entry(TRAIL_VAR_W'(var_q), val_q, type_q)),
    .top_o        (trail_top),
    .empty_o      (trail_empty),
    .full_o       (trail_full),
    .count_o      (trail_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      var_q       <= '0;
      val_q       <= 1'b0;
      type_q      <= TYPE_FORCED;
      level_q     <= '0;
      conflicts_q <= '0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      var_q       <= var_d;
      val_q       <= val_d;
      type_q      <= type_d;
      level_q     <= level_d;
      conflicts_q <= conflicts_d;
      err_q       <= err_d;
      flush_q     <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    var_d       = var_q;
    val_d       = val_q;
    type_d      = type_q;
    level_d     = level_q;
    conflicts_d = conflicts_q;
    err_d       = err_q;
    flush_d     = 1'b0;
    trail_push  = 1'b0;
    trail_pop   = 1'b0;
    trail_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_SAT, ST_UNSAT: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          trail_clear = 1'b1;
          level_d     = '0;
          conflicts_d = '0;
          err_d       = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bus.imp_valid) begin
          var_d   = bus.imp_var;
          val_d   = bus.imp_val;
          type_d  = TYPE_FORCED;
          state_d = ST_ASSIGN;
        end else begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (bus.dec_none) begin
          state_d = ST_SAT;
        end else if (bus.dec_valid) begin
          var_d   = bus.dec_var;
          val_d   = bus.dec_val;
          type_d  = TYPE_DECISION;
          level_d = level_q + (VAR_W+1)'(1);
          state_d = ST_ASSIGN;
        end
      end
      ST_ASSIGN: begin
        if (trail_full) begin
          err_d   = 1'b1;
          state_d = ST_UNSAT;
        end else begin
          trail_push = 1'b1;
          state_d    = ST_BCP;
        end
      end
      ST_BCP: state_d = ST_WAIT_BCP;
      ST_WAIT_BCP: begin
        if (bus.bcp_done) begin
          if (bus.bcp_conflict) begin
            flush_d = 1'b1;
            if (conflicts_q != {CNT_W{1'b1}}) conflicts_d = conflicts_q + CNT_W'(1);
            state_d = ST_BACKTRACK;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_BACKTRACK: begin
        if (trail_count == '0) begin
          state_d = ST_UNSAT;
        end else begin
          trail_pop = 1'b1;
          // The most recent decision gets flipped and re-enters the trail as forced.
          if (trail_top.is_decision == TYPE_DECISION) begin
            var_d   = VAR_W'(trail_top.var_idx);
            val_d   = ~trail_top.val;
            type_d  = TYPE_FORCED;
            level_d = level_q - (VAR_W+1)'(1);
            state_d = ST_ASSIGN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.imp_ready = (state_q == ST_FETCH);
    bus.imp_flush = flush_q;
    bus.dec_req   = (state_q == ST_DECIDE);
    bus.asg_we    = 1'b0;
    bus.asg_var   = '0;
    bus.asg_val   = 1'b0;
    bus.asg_clear = 1'b0;
    if (state_q == ST_ASSIGN && !trail_full) begin
      bus.asg_we  = 1'b1;
      bus.asg_var = var_q;
      bus.asg_val = val_q;
    end else if (state_q == ST_BACKTRACK && !trail_empty) begin
      bus.asg_we    = 1'b1;
      bus.asg_clear = 1'b1;
      bus.asg_var   = VAR_W'(trail_top.var_idx);
    end
    bus.bcp_start = (state_q == ST_BCP);
    bus.bcp_var   = (state_q == ST_BCP) ? var_q : '0;
    bus.bcp_val   = (state_q == ST_BCP) ? val_q : 1'b0;
    bus.busy      = !(state_q == ST_IDLE || state_q == ST_SAT || state_q == ST_UNSAT);
    bus.sat       = (state_q == ST_SAT);
    bus.unsat     = (state_q == ST_UNSAT);
    bus.level     = level_q;
    bus.conflicts = conflicts_q;
    bus.err       = err_q;
  end

endmodule

// File: doc/solver_ctrl.md
# solver_ctrl

Parametrised DPLL search controller, successor to the single-stack control FSM. It sequences the solve loop: fetch implication, else decide, then assign, then BCP, then wait. On conflict it performs chronological backtracking through an internal assignment trail, which clears assignments and flips the most recent unflipped decision. It sits between the implication queue, the decide unit, the variable-state table and the clause-evaluation/BCP engine, and reports SAT/UNSAT plus search statistics.

## Interface
- `NUM_VARIABLE`, 128: number of variables; also the trail depth.
- `VAR_W`, `$clog2(NUM_VARIABLE)`: variable index width.
- `CNT_W`, 32: conflict counter width.

- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a solve; ignored unless in IDLE, SAT or UNSAT.
- `imp_valid` in 1, `imp_var` in VAR_W, `imp_val` in 1: head of the implication queue.
- `imp_ready` out 1: pops the queue head when `imp_valid & imp_ready`.
- `imp_flush` out 1: one-cycle pulse that empties the implication queue.
- `dec_req` out 1: request for a decision.
- `dec_valid` in 1, `dec_var` in VAR_W, `dec_val` in 1: decision response.
- `dec_none` in 1: all variables are assigned.
- `asg_we` out 1, `asg_var` out VAR_W, `asg_val` out 1, `asg_clear` out 1: variable-state table write port; `asg_clear=1` marks the variable unassigned.
- `bcp_start` out 1, `bcp_var` out VAR_W, `bcp_val` out 1: one-cycle BCP launch.
- `bcp_done` in 1, `bcp_conflict` in 1: BCP completion; `bcp_conflict` is valid only while `bcp_done` is high.
- `busy` out 1: high in every state except IDLE, SAT and UNSAT.
- `sat` out 1, `unsat` out 1: sticky result flags.
- `level` out VAR_W+1: current decision level.
- `conflicts` out CNT_W: conflict count, saturating.
- `err` out 1: sticky; set on trail overflow.

## Operation
- States: IDLE, FETCH, DECIDE, ASSIGN, BCP, WAIT_BCP, BACKTRACK, SAT, UNSAT.
- IDLE/SAT/UNSAT + `start`:
  - go to FETCH;
  - clear the trail, `level`, `conflicts`, `sat`, `unsat` and `err`.
- FETCH: `imp_ready=1`.
  - If `imp_valid`: latch var/val with type FORCED, go to ASSIGN.
  - Otherwise go to DECIDE.
- DECIDE: hold `dec_req=1` until a response.
  - `dec_none` goes to SAT; it has priority over `dec_valid`.
  - `dec_valid`: latch var/val with type DECISION, `level+1`, go to ASSIGN.
- ASSIGN (1 cycle):
  - `asg_we=1`, `asg_clear=0`;
  - push {var, val, type} onto the trail;
  - go to BCP.
- BCP (1 cycle): `bcp_start=1` with the latched var/val, then go to WAIT_BCP.
- WAIT_BCP: wait for `bcp_done`.
  - Conflict: pulse `imp_flush`, `conflicts+1`, go to BACKTRACK.
  - No conflict: go to FETCH.
- BACKTRACK: one trail entry per cycle.
  - Trail empty: go to UNSAT.
  - Otherwise pop the top entry and clear its assignment: `asg_we=1`, `asg_clear=1`, `asg_var=top.var`.
  - Top is a DECISION: latch {top.var, ~top.val, FORCED}, `level-1`, go to ASSIGN.
  - Top is FORCED: stay in BACKTRACK.
- `sat`/`unsat` are high only in their states.
- Push while the trail is full sets `err`; the push is dropped and the FSM goes to UNSAT.

## Timing
- Reset value of every output is 0; the trail is empty and the state is IDLE.
- Reset asserted mid-solve aborts immediately; no further `asg_we` is issued.
- Minimum cost of one assignment: 4 cycles (FETCH → ASSIGN → BCP → WAIT_BCP), with `bcp_done` arriving in the cycle after `bcp_start`.
- A backtrack over k entries takes k cycles of BACKTRACK, then one ASSIGN.
- Trail pop and push never occur in the same cycle.
- Trail top output is registered and valid in the cycle after a push or pop.
- All handshake outputs are registered-state decodes (Moore); no input-to-output combinational paths.
- `conflicts` saturates at all-ones.

## Structure
- Package `solver_pkg`:
  - `trail_entry_t` {var, val, is_decision};
  - `ctrl_state_t` enum;
  - `TYPE_DECISION` / `TYPE_FORCED` constants.
- Sub-module `assign_trail`:
  - LIFO of `trail_entry_t`, depth NUM_VARIABLE;
  - push, pop, clear, top, empty, full, count;
  - asynchronous active-low reset.

## Test plan
- Reset: hold `reset_n=0` mid-WAIT_BCP → all outputs 0, `busy=0`, trail empty.
- `start`, implication queue empty, `dec_valid` var=3 val=1, no BCP conflict, then `dec_none` → `asg_we` var 3 val 1, `bcp_start` var 3, `level=1`, `sat=1`.
- FETCH with `imp_valid` var=5 val=0 → `imp_ready` pops it, FORCED push, `level` unchanged, `bcp_var=5`.
- Decide v1=1, imply v2=0, `bcp_conflict` → `imp_flush` pulse, clear v2, clear v1, assign v1=0, `level=0`, `conflicts=1`.
- Conflict with trail holding only FORCED v4 and v7 → clears v7 then v4 on consecutive cycles, then `unsat=1`, `busy=0`.
- `start` asserted during WAIT_BCP → ignored; `start` in SAT → flags cleared, new solve begins.
